result_bcd_converter: RTL and testbench

- Sequential binary-to-BCD converter that sits directly downstream of the cubic/multiply function unit.
- Takes that unit's binary result and produces packed BCD digits for the display/output stage.
- Uses iterative shift-and-add-3 (double dabble), one bit per clock.
- Uses the same enable/busy/finish handshake as the arithmetic units.

---
 rtl/result_bcd_converter.sv | 108 ++++++++++
 tb/tb_result_bcd_converter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) that
// formats the arithmetic unit's result for the display stage.
module result_bcd_converter #(
  parameter int WIDTH  = 24,
  parameter int DIGITS = 8,
  parameter int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  finish,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [CNT_W-1:0]      digit_count
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CTR_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [BCD_W-1:0]   r_scratch;
  logic [CTR_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_finish;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_digit_count;

  logic [BCD_W-1:0]   w_next_scratch;
  logic [3:0]         w_nib;
  logic               w_carry;

  function automatic logic [CNT_W-1:0] sig_digits(input logic [BCD_W-1:0] d);
    logic [CNT_W-1:0] n;
    n = CNT_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] != 4'd0) n = CNT_W'(i + 1);
    end
    return n;
  endfunction

  // Add-3 and shift in one pass: each adjusted nibble's MSB carries into the
  // next nibble's LSB; the carry out of the top nibble is always zero.
  always_comb begin
    w_next_scratch = '0;
    w_nib          = '0;
    w_carry        = r_shift[WIDTH-1];
    for (int i = 0; i < DIGITS; i++) begin
      w_nib = r_scratch[4*i +: 4];
      if (w_nib >= 4'd5) w_nib = w_nib + 4'd3;
      w_next_scratch[4*i +: 4] = {w_nib[2:0], w_carry};
      w_carry = w_nib[3];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_scratch     <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_finish      <= 1'b0;
      r_bcd         <= '0;
      r_digit_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_shift   <= value;
            r_scratch <= '0;
            r_cnt     <= CTR_W'(WIDTH);
            r_finish  <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          r_scratch <= w_next_scratch;
          r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
          r_cnt     <= r_cnt - CTR_W'(1);
          if (r_cnt == CTR_W'(1)) r_state <= S_DONE;
        end
        S_DONE: begin
          r_bcd         <= r_scratch;
          r_digit_count <= sig_digits(r_scratch);
          r_finish      <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign finish      = r_finish;
  assign bcd         = r_bcd;
  assign digit_count = r_digit_count;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed bench for result_bcd_converter: expected BCD results are queued at
// stimulus time and checked with immediate assertions when finish rises.
module tb_result_bcd_converter;

  localparam int WIDTH  = 24;
  localparam int DIGITS = 8;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int LAT    = WIDTH + 1;

  logic                clock = 1'b0;
  logic                reset;
  logic                enable;
  logic [WIDTH-1:0]    value;
  logic                busy;
  logic                finish;
  logic [4*DIGITS-1:0] bcd;
  logic [CNT_W-1:0]    digit_count;

  typedef struct {
    logic [31:0] bcd;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  result_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .value       (value),
    .busy        (busy),
    .finish      (finish),
    .bcd         (bcd),
    .digit_count (digit_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_cnt(input int unsigned v);
    int unsigned t;
    int n;
    t = v;
    n = 1;
    while (t >= 10) begin
      t = t / 10;
      n++;
    end
    return 32'(n);
  endfunction

  task automatic push_exp(input int unsigned v);
    exp_t e;
    e.bcd = model_bcd(v);
    e.cnt = model_cnt(v);
    q.push_back(e);
  endtask

  // Drives one accepting edge; returns #1 after that edge with enable low.
  task automatic start(input int unsigned v, input bit expect_result);
    @(negedge clock);
    enable = 1'b1;
    value  = WIDTH'(v);
    if (expect_result) push_exp(v);
    @(posedge clock);
    #1;
    enable = 1'b0;
    value  = WIDTH'($urandom);
  endtask

  // Called #1 after the accepting edge. Optionally pulses enable=999 while busy.
  task automatic wait_result(input string tag, input int inject_at);
    int   cyc;
    int   nb;
    bit   seen;
    exp_t e;
    cyc  = 0;
    seen = 1'b0;
    nb   = busy ? 1 : 0;
    while (!seen && cyc < LAT + 15) begin
      @(posedge clock);
      #1;
      cyc++;
      if (inject_at != 0 && cyc == inject_at + 1) enable = 1'b0;
      if (finish) seen = 1'b1;
      else begin
        if (busy) nb++;
        if (inject_at != 0 && cyc == inject_at) begin
          enable = 1'b1;
          value  = WIDTH'(999);
        end
      end
    end
    chk({tag, " latency"}, 32'(cyc), 32'(LAT));
    chk({tag, " busy_cycles"}, 32'(nb), 32'(LAT));
    chk({tag, " busy_at_finish"}, 32'(busy), 32'd0);
    e.bcd = 32'hDEAD_BEEF;
    e.cnt = 32'hFFFF_FFFF;
    if (q.size() > 0) e = q.pop_front();
    chk({tag, " bcd"}, 32'(bcd), e.bcd);
    chk({tag, " digit_count"}, 32'(digit_count), e.cnt);
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    value  = '0;
    #2 reset = 1'b1;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset finish", 32'(finish), 32'd0);
    chk("reset bcd", 32'(bcd), 32'd0);
    chk("reset digit_count", 32'(digit_count), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    start(0, 1'b1);
    wait_result("zero", 0);
    start(1234, 1'b1);
    wait_result("v1234", 0);
    start(24'hFFFFFF, 1'b1);
    wait_result("max", 0);

    // Upstream 3^3 + 3*5 = 42, with an ignored enable pulse mid-conversion
    start(42, 1'b1);
    wait_result("up42", 5);
    @(posedge clock);
    #1;
    chk("up42 no_restart busy", 32'(busy), 32'd0);
    chk("up42 finish_level", 32'(finish), 32'd1);

    // Asynchronous reset in the middle of a conversion
    start(1234, 1'b0);
    repeat (10) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset finish", 32'(finish), 32'd0);
    chk("midreset bcd", 32'(bcd), 32'd0);
    chk("midreset digit_count", 32'(digit_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    start(7, 1'b1);
    wait_result("v7", 0);

    // Enable held high across two conversions
    @(negedge clock);
    enable = 1'b1;
    value  = WIDTH'(100);
    push_exp(100);
    push_exp(5);
    @(posedge clock);
    #1;
    value = WIDTH'(5);
    wait_result("b2b first", 0);
    @(posedge clock);
    #1;
    enable = 1'b0;
    chk("b2b finish_one_cycle", 32'(finish), 32'd0);
    chk("b2b second_busy", 32'(busy), 32'd1);
    chk("b2b bcd_held", 32'(bcd), 32'h0000_0100);
    chk("b2b count_held", 32'(digit_count), 32'd3);
    wait_result("b2b second", 0);

    for (int i = 0; i < 3; i++) begin
      int unsigned rv;
      rv = $urandom_range(0, (1 << WIDTH) - 1);
      start(rv, 1'b1);
      wait_result("random", 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
